// File: rtl/tlb_refill_walker_pkg.sv
// rtl/tlb_refill_walker_pkg.sv - shared constants and helpers for the TLB refill walker
package tlb_refill_walker_pkg;

  localparam int VPN_W       = 20;
  localparam int PFN_W       = 20;
  localparam int IDX_W       = 5;

  // PTE layout: [31:12] PFN, [2] cacheable, [1] writable, [0] valid
  localparam int PTE_PFN_LSB = 12;
  localparam int PTE_V       = 0;
  localparam int PTE_W       = 1;
  localparam int PTE_C       = 2;

  localparam logic [4:0] CP0_REASON_DEFAULT = 5'd10;
  localparam logic [4:0] CP0_PT_DEFAULT     = 5'd11;

  // Slot 0 is reserved, so the round-robin victim range is 1..31
  localparam logic [IDX_W-1:0] VICTIM_FIRST = 5'd1;
  localparam logic [IDX_W-1:0] VICTIM_LAST  = 5'd31;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_BASE  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_FILL  = 3'd5;
  localparam logic [2:0] ST_FAULT = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // TLB entry: {VPN, 12'b0, PFN, 9'b0, C, W, V}
  function automatic logic [63:0] make_entry(input logic [VPN_W-1:0] vpn,
                                             input logic [PFN_W-1:0] pfn,
                                             input logic c, input logic w, input logic v);
    make_entry = {vpn, 12'h000, pfn, 9'h000, c, w, v};
  endfunction

  // Fault reason word: {VPN, 9'b0, WP, IS_INST, INVALID}
  function automatic logic [31:0] make_reason(input logic [VPN_W-1:0] vpn,
                                              input logic wp, input logic is_inst,
                                              input logic invalid);
    make_reason = {vpn, 9'h000, wp, is_inst, invalid};
  endfunction

endpackage

// File: rtl/tlb_victim_ptr.sv
// rtl/tlb_victim_ptr.sv - round-robin TLB victim slot counter over 1..31
module tlb_victim_ptr
  import tlb_refill_walker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [IDX_W-1:0] ptr
);

  // Advance one slot per fill, skipping the reserved slot 0 on wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= VICTIM_FIRST;
    end else if (en) begin
      ptr <= (ptr == VICTIM_LAST) ? VICTIM_FIRST : ptr + 5'd1;
    end
  end

endmodule

// File: rtl/tlb_refill_walker.sv
// rtl/tlb_refill_walker.sv - hardware TLB refill walker with fault reporting to CP0
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
#(
  parameter int         ADDR_WIDTH      = 32,
  parameter int         DATA_WIDTH      = 32,
  parameter logic [4:0] CP0_REASON_ADDR = CP0_REASON_DEFAULT,
  parameter logic [4:0] CP0_PT_ADDR     = CP0_PT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [VPN_W-1:0]      i_miss_vpn,
  output logic                  i_miss_ack,
  input  logic                  d_miss_req,
  input  logic [VPN_W-1:0]      d_miss_vpn,
  input  logic                  d_miss_store,
  output logic                  d_miss_ack,
  output logic                  tlb_we,
  output logic                  tlb_sel,
  output logic [IDX_W-1:0]      tlb_index,
  output logic [63:0]           tlb_entry,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic [4:0]            cp0_addr_r,
  input  logic [DATA_WIDTH-1:0] cp0_data_r,
  output logic                  cp0_we,
  output logic [4:0]            cp0_addr_w,
  output logic [DATA_WIDTH-1:0] cp0_data_w,
  output logic                  pf_exception,
  output logic                  busy
);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic                  side_data;   // 1 = walk serves the data TLB
  logic                  store;
  logic [VPN_W-1:0]      vpn;
  logic [PFN_W-1:0]      pte_pfn;
  logic                  pte_c;
  logic                  pte_w;
  logic                  pte_v;
  logic [IDX_W-1:0]      i_ptr;
  logic [IDX_W-1:0]      d_ptr;
  logic                  wp;
  logic                  invalid;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] pte_addr;
  logic                  unused_bits;

  assign cp0_addr_r = CP0_PT_ADDR;

  // PTE address wraps modulo 2^ADDR_WIDTH; the carry out is intentionally dropped
  assign pte_addr = ADDR_WIDTH'({cp0_data_r[DATA_WIDTH-1:PTE_PFN_LSB], 12'h000})
                  + ADDR_WIDTH'({vpn, 2'b00});

  assign invalid = ~pte_v;
  assign wp      = side_data & store & ~pte_w;
  assign fault   = invalid | wp;

  assign unused_bits = ^{cp0_data_r[PTE_PFN_LSB-1:0], mem_data[PTE_PFN_LSB-1:PTE_C+1]};

  tlb_victim_ptr u_i_ptr (
    .clk (clk),
    .rst (rst),
    .en  ((state == ST_FILL) && !side_data),
    .ptr (i_ptr)
  );

  tlb_victim_ptr u_d_ptr (
    .clk (clk),
    .rst (rst),
    .en  ((state == ST_FILL) && side_data),
    .ptr (d_ptr)
  );

  // Walk sequencing; the read state stretches for as long as memory stalls
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (d_miss_req || i_miss_req) next_state = ST_LATCH;
      ST_LATCH: next_state = ST_BASE;
      ST_BASE:  next_state = ST_READ;
      ST_READ:  if (mem_ready) next_state = ST_CHECK;
      ST_CHECK: next_state = fault ? ST_FAULT : ST_FILL;
      ST_FILL:  next_state = ST_DONE;
      ST_FAULT: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State and strobes are registered from the next state so every pulse lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      mem_rd       <= 1'b0;
      tlb_we       <= 1'b0;
      cp0_we       <= 1'b0;
      pf_exception <= 1'b0;
      i_miss_ack   <= 1'b0;
      d_miss_ack   <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= (next_state != ST_IDLE);
      mem_rd       <= (next_state == ST_READ);
      tlb_we       <= (next_state == ST_FILL);
      cp0_we       <= (next_state == ST_FAULT);
      pf_exception <= (next_state == ST_FAULT);
      i_miss_ack   <= ((next_state == ST_FILL) || (next_state == ST_FAULT)) && !side_data;
      d_miss_ack   <= ((next_state == ST_FILL) || (next_state == ST_FAULT)) && side_data;
    end
  end

  // Walk datapath: grant, request capture, PTE fetch and the fill/fault payloads
  always_ff @(posedge clk) begin
    if (rst) begin
      side_data  <= 1'b0;
      store      <= 1'b0;
      vpn        <= '0;
      pte_pfn    <= '0;
      pte_c      <= 1'b0;
      pte_w      <= 1'b0;
      pte_v      <= 1'b0;
      mem_addr   <= '0;
      tlb_sel    <= 1'b0;
      tlb_index  <= '0;
      tlb_entry  <= '0;
      cp0_addr_w <= '0;
      cp0_data_w <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Data side wins a tie; the inst request stays pending until the next walk
          side_data <= d_miss_req;
        end
        ST_LATCH: begin
          vpn   <= side_data ? d_miss_vpn : i_miss_vpn;
          store <= side_data & d_miss_store;
        end
        ST_BASE: begin
          mem_addr <= pte_addr;
        end
        ST_READ: begin
          if (mem_ready) begin
            pte_pfn <= mem_data[DATA_WIDTH-1:PTE_PFN_LSB];
            pte_c   <= mem_data[PTE_C];
            pte_w   <= mem_data[PTE_W];
            pte_v   <= mem_data[PTE_V];
          end
        end
        ST_CHECK: begin
          if (fault) begin
            cp0_addr_w <= CP0_REASON_ADDR;
            cp0_data_w <= make_reason(vpn, wp, ~side_data, invalid);
          end else begin
            tlb_sel   <= side_data;
            tlb_index <= side_data ? d_ptr : i_ptr;
            tlb_entry <= make_entry(vpn, pte_pfn, pte_c, pte_w, pte_v);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// tb/tb_tlb_refill_walker.sv - scoreboard bench for the TLB refill walker
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0;
  logic [19:0] i_miss_vpn = '0;
  logic        i_miss_ack;
  logic        d_miss_req = 1'b0;
  logic [19:0] d_miss_vpn = '0;
  logic        d_miss_store = 1'b0;
  logic        d_miss_ack;
  logic        tlb_we;
  logic        tlb_sel;
  logic [4:0]  tlb_index;
  logic [63:0] tlb_entry;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic [4:0]  cp0_addr_r;
  logic [31:0] cp0_data_r;
  logic        cp0_we;
  logic [4:0]  cp0_addr_w;
  logic [31:0] cp0_data_w;
  logic        pf_exception;
  logic        busy;

  logic [31:0] pt_base = '0;

  always #5 clk = ~clk;

  assign cp0_data_r = (cp0_addr_r == 5'd11) ? pt_base : 32'hBAD0_0BAD;

  tlb_refill_walker dut (
    .clk          (clk),
    .rst          (rst),
    .i_miss_req   (i_miss_req),
    .i_miss_vpn   (i_miss_vpn),
    .i_miss_ack   (i_miss_ack),
    .d_miss_req   (d_miss_req),
    .d_miss_vpn   (d_miss_vpn),
    .d_miss_store (d_miss_store),
    .d_miss_ack   (d_miss_ack),
    .tlb_we       (tlb_we),
    .tlb_sel      (tlb_sel),
    .tlb_index    (tlb_index),
    .tlb_entry    (tlb_entry),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .cp0_addr_r   (cp0_addr_r),
    .cp0_data_r   (cp0_data_r),
    .cp0_we       (cp0_we),
    .cp0_addr_w   (cp0_addr_w),
    .cp0_data_w   (cp0_data_w),
    .pf_exception (pf_exception),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fault;
    bit          sel;
    logic [4:0]  idx;
    logic [63:0] entry;
    logic [31:0] reason;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pte;
    int          w;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   vict[2];     // next victim slot per side: 0 = inst, 1 = data
  bit   stall = 1'b0;
  bit   resp_active = 1'b0;
  rd_t  resp_cur;
  int   resp_left;

  // Reference model: what one walk must produce, pushed in service order
  function automatic void model_walk(input bit sel, input logic [19:0] vpn, input bit store,
                                     input logic [31:0] pte, input int w);
    exp_t e;
    rd_t  r;
    bit   invalid;
    bit   wp;
    r.addr = (pt_base & 32'hFFFF_F000) + 32'(vpn) * 32'd4;
    r.pte  = pte;
    r.w    = w;
    rd_q.push_back(r);
    invalid = (pte[0] == 1'b0);
    wp      = sel && store && (pte[1] == 1'b0);
    e.fault = invalid || wp;
    e.sel   = sel;
    if (!e.fault) begin
      e.idx      = 5'(vict[sel]);
      vict[sel]  = vict[sel] % 31 + 1;
      e.entry    = {vpn, 12'h000, pte[31:12], 9'h000, pte[2:0]};
      e.reason   = '0;
    end else begin
      e.idx      = '0;
      e.entry    = '0;
      e.reason   = {vpn, 9'h000, wp, !sel, invalid};
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: every TLB or CP0 write is matched against the head of the scoreboard
  exp_t me;
  logic prev_we = 0, prev_cp0 = 0, prev_ia = 0, prev_da = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tlb_we || cp0_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {tlb_we, cp0_we}, 0);
        end else begin
          me = exp_q.pop_front();
          chk("fault_kind", cp0_we, me.fault);
          chk("single_write", tlb_we && cp0_we, 0);
          if (me.fault) begin
            chk("cp0_data_w", cp0_data_w, me.reason);
            chk("cp0_addr_w", cp0_addr_w, 10);
            chk("pf_with_cp0_we", pf_exception, 1);
          end else begin
            chk("tlb_sel", tlb_sel, me.sel);
            chk("tlb_index", tlb_index, me.idx);
            chk("tlb_entry", tlb_entry, me.entry);
            chk("pf_quiet_on_fill", pf_exception, 0);
          end
          chk("i_ack_with_write", i_miss_ack, !me.sel);
          chk("d_ack_with_write", d_miss_ack, me.sel);
        end
      end else if (i_miss_ack || d_miss_ack || pf_exception) begin
        chk("stray_pulse", {i_miss_ack, d_miss_ack, pf_exception}, 0);
      end
      if (tlb_we)     chk("tlb_we_width", prev_we, 0);
      if (cp0_we)     chk("cp0_we_width", prev_cp0, 0);
      if (i_miss_ack) chk("i_ack_width", prev_ia, 0);
      if (d_miss_ack) chk("d_ack_width", prev_da, 0);
    end
    prev_we  <= tlb_we;
    prev_cp0 <= cp0_we;
    prev_ia  <= i_miss_ack;
    prev_da  <= d_miss_ack;
  end

  // Memory responder: serves queued PTEs after a per-walk number of wait cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_data  = '0;
      end else if (mem_rd && !stall && !rst) begin
        if (!resp_active) begin
          if (rd_q.size() == 0) begin
            chk("unexpected_read", 1, 0);
          end else begin
            resp_cur    = rd_q.pop_front();
            resp_active = 1'b1;
            resp_left   = resp_cur.w;
            chk("mem_addr", mem_addr, resp_cur.addr);
          end
        end
        if (resp_active) begin
          if (resp_left == 0) begin
            mem_ready   = 1'b1;
            mem_data    = resp_cur.pte;
            resp_active = 1'b0;
          end else begin
            resp_left--;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    i_miss_req = 1'b0;
    d_miss_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_ready   = 1'b0;
    resp_active = 1'b0;
    vict[0]     = 1;
    vict[1]     = 1;
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic run_round(input bit use_i, input bit use_d,
                           input logic [19:0] ivpn, input logic [19:0] dvpn, input bit dstore,
                           input logic [31:0] ipte, input logic [31:0] dpte,
                           input int iw, input int dw);
    bit got_i, got_d;
    int n, m, idle, lat_i, lat_d;
    if (use_d) model_walk(1'b1, dvpn, dstore, dpte, dw);
    if (use_i) model_walk(1'b0, ivpn, 1'b0, ipte, iw);
    i_miss_vpn   = ivpn;
    d_miss_vpn   = dvpn;
    d_miss_store = dstore;
    i_miss_req   = use_i;
    d_miss_req   = use_d;
    got_i = !use_i;
    got_d = !use_d;
    n = 0; idle = 0; lat_i = 0; lat_d = 0;
    while (!(got_i && got_d) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (i_miss_ack) begin
        if (got_i) chk("i_ack_once", 1, 0);
        got_i = 1'b1; i_miss_req = 1'b0; lat_i = n;
      end
      if (d_miss_ack) begin
        if (got_d) chk("d_ack_once", 1, 0);
        got_d = 1'b1; d_miss_req = 1'b0; lat_d = n;
      end
      if (use_i && use_d && got_d && !got_i && !busy) idle++;
    end
    if (!(got_i && got_d)) begin
      chk("round_timeout", {got_i, got_d}, 2'b11);
      do_reset();
      return;
    end
    if (use_d) chk("d_latency", lat_d, 5 + dw);
    if (use_i && !use_d) chk("i_latency", lat_i, 5 + iw);
    if (use_i && use_d) begin
      chk("dual_idle_gap", idle, 1);
      chk("dual_i_latency", lat_i, lat_d + 7 + iw);
    end
    m = 0;
    while (busy && m < 10) begin
      @(posedge clk);
      #1;
      m++;
    end
    chk("idle_after_walk", busy, 0);
  endtask

  function automatic logic [31:0] rand_pte();
    if ($urandom_range(0, 5) == 0) return 32'h0;
    return $urandom;
  endfunction

  initial begin
    logic [19:0] v1, v2;
    int n;
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_tlb_we", tlb_we, 0);
    chk("rst_cp0_we", cp0_we, 0);
    chk("rst_pf", pf_exception, 0);
    chk("rst_acks", {i_miss_ack, d_miss_ack}, 0);
    chk("rst_tlb_entry", tlb_entry, 0);
    chk("rst_tlb_index", tlb_index, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cp0_data_w", cp0_data_w, 0);
    chk("cp0_addr_r", cp0_addr_r, 11);

    // Directed inst fill with one memory wait cycle
    pt_base = 32'h0010_0000;
    run_round(1, 0, 20'h00403, 20'h0, 0, 32'h1234_5003, 32'h0, 1, 0);

    // Simultaneous requests: data side first
    run_round(1, 1, 20'h1_2345, 20'h5_4321, 0, 32'hABCD_E007, 32'h0F0F_0003, 0, 2);

    // Store to a write-protected page
    run_round(0, 1, 20'h0, 20'h7_7777, 1, 32'h0, 32'h00AB_C001, 0, 0);

    // Invalid PTE on the inst side, then a fill that must reuse the same slot
    run_round(1, 0, 20'h0_0BAD, 20'h0, 0, 32'h0, 32'h0, 0, 0);
    run_round(1, 0, 20'h0_0600, 20'h0, 0, 32'h0000_2005, 32'h0, 0, 0);

    // 32 inst fills wrap the inst pointer; the data pointer is untouched
    for (int k = 0; k < 32; k++) begin
      v1 = 20'($urandom);
      run_round(1, 0, v1, 20'h0, 0, ($urandom & 32'hFFFF_F006) | 32'h1, 32'h0, 0, 0);
    end
    run_round(0, 1, 20'h0, 20'h3_0303, 1, 32'h0, 32'h5555_5003, 0, 1);

    // Reset in the middle of a stalled PTE read
    stall      = 1'b1;
    i_miss_vpn = 20'h4_4444;
    i_miss_req = 1'b1;
    n = 0;
    while (!mem_rd && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_reached_read", mem_rd, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_rd_held", mem_rd, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midwalk_rst_mem_rd", mem_rd, 0);
    chk("midwalk_rst_busy", busy, 0);
    chk("midwalk_rst_acks", {i_miss_ack, d_miss_ack, tlb_we, cp0_we}, 0);
    i_miss_req = 1'b0;
    stall      = 1'b0;
    do_reset();
    run_round(1, 0, 20'h4_4444, 20'h0, 0, 32'h0009_9001, 32'h0, 0, 0);

    // Randomized rounds with random base (including wrap), PTEs and wait states
    for (int r = 0; r < 40; r++) begin
      int kind;
      kind    = $urandom_range(0, 2);
      pt_base = $urandom;
      v1      = 20'($urandom);
      v2      = 20'($urandom);
      run_round(kind != 1, kind != 0, v1, v2, 1'($urandom), rand_pte(), rand_pte(),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("reads_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
